jt12_pg_seq: RTL
================

# jt12_pg_seq

Time-multiplexed phase generator sequencer for the 24 FM operator slots (6 channels × 4 operators). It sits between the register file and the operator/EG pipeline. For each slot it accepts the per-slot frequency parameters, runs them through the combinational phase stage, and holds every slot's 20-bit phase in a 24-stage circular store. It emits the 10-bit operator phase and the keycode in slot order with a fixed latency.

## Interface
Parameters:
- SLOTS, 24, number of time-multiplexed operator slots (store depth).
- PW, 20, phase accumulator width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- clk_en  in  1  slot advance enable; all state moves only when high.
- block_I  in  3  octave for the slot entering stage I.
- fnum_I  in  11  frequency number, stage I.
- lfo_mod  in  5  current LFO phase-modulation value (global).
- pms_I  in  3  PM sensitivity, stage I.
- detune_I  in  3  detune code, stage I.
- mul_II  in  4  frequency multiplier, aligned to stage II.
- keyon_II  in  1  phase reset request, aligned to stage II (one slot wide).
- keycode_II  out  5  keycode of the slot in stage II; feeds the EG rate scaler.
- phase_op_III  out  10  operator phase for the slot in stage III; feeds the operator.
- slot_III  out  5  slot index 0..23 of the slot presented on phase_op_III.
- zero  out  1  high for the one clk_en period in which slot 0 is in stage I.

## Operation
- Slot counter cnt (5 b): resets to 0. On clk_en it increments, and 23 wraps to 0. The stage I inputs belong to slot cnt.
- Stage I (comb): computes keycode, signed 6-bit detune and 17-bit phinc from block_I, fnum_I, lfo_mod, pms_I and detune_I.
- Stage II (registered on clk_en): keycode_II, detune_II and phinc_II. Outputs keycode_II directly.
- Stage III (registered on clk_en):
  - phase_out = phase_in + ((phinc_II + detune_II) × mul_II), modulo 2^20.
  - When mul_II = 0, the multiplier is ½ (the sum shifted right by 1).
  - When keyon_II = 1, phase_out = 0.
  - phase_op_III = phase_out[19:10].
  - slot_III = slot index of the slot being processed.
- Phase store: a shift register of SLOTS × PW bits advanced on clk_en.
  - phase_in is the tail entry; phase_out enters at the head.
  - Each slot's phase therefore returns to stage III exactly 24 clk_en periods later.
  - The store is never addressed randomly.
- The detune sum is signed, and a negative total wraps modulo 2^20. Overflow of phase is silent wrap-around.
- Parameter changes take effect on the next visit of that slot. No phase discontinuity is introduced other than the increment change.
- keyon_II and the phase update are the only paths into the store. keyon takes priority over accumulation in the same cycle.

## Timing
- Reset (rst_n low, asynchronous): all outputs and state go to 0.
  - cnt = 0, zero = 0, keycode_II = 0, phase_op_III = 0, slot_III = 0.
  - All 24 stored phases = 0.
- First clk_en after reset release: zero = 1, because slot 0 is in stage I.
- Latency:
  - Stage I inputs for slot s produce keycode_II 1 clk_en later.
  - The same slot's phase_op_III appears 2 clk_en later, with slot_III = s.
- clk_en low: every register holds and outputs are stable. There is no minimum clk_en spacing.
- Reset asserted mid-frame: the frame is abandoned and the store is cleared. After release, the slot sequence restarts at slot 0 with no stale phase.

## Structure
- Shared package or header: SLOTS = 24, PW = 20, stage widths (keycode 5, detune 6, phinc 17, phase_op 10).
- One sub-module instance: jt12_pg_comb.
  - Its phase-increment and detune outputs feed the stage II registers.
  - Its phase-sum section is driven from stage II and the store tail.
- This block owns only the counter, pipeline registers, store and alignment. It holds no frequency arithmetic of its own.

## Test plan
- Reset values: assert rst_n low mid-run, then release.
  - Required: all outputs 0.
  - zero = 1 on the first clk_en.
  - Every slot's first phase_op_III = 0 unless a nonzero increment is applied.
- Basic accumulation: slot 5 with block = 4, fnum = 1024, pms = 0, detune = 0, mul = 1, all other slots at mul = 0, fnum = 0.
  - Required: slot 5's stored phase grows by 8192 per frame (24 clk_en).
  - phase_op_III for slot 5 grows by 8 per frame.
- Multiplier ½: same setup as basic accumulation with mul = 0.
  - Required: increment 4096 per frame.
  - mul = 3 gives 24576 per frame.
- Keyon reset: pulse keyon_II during slot 5's stage II after 10 frames.
  - Required: that slot's next phase_op_III = 0, then accumulation restarts.
  - Other slots are unaffected.
- Wrap-around: run slot 0 at increment 8192 for 128 frames.
  - Required: phase returns to 0 (2^20 wrap) with no glitch.
- clk_en gating: hold clk_en low for 7 cycles mid-frame.
  - Required: outputs and cnt frozen.
  - The sequence resumes with identical values to an ungated run.

Source files
------------

// File: rtl/jt12_pg_seq_pkg.sv
// Shared widths and stage-II record for the phase-generator sequencer.
package jt12_pg_seq_pkg;

    localparam int unsigned PG_SLOTS = 24;
    localparam int unsigned PG_PW    = 20;
    localparam int unsigned KC_W     = 5;
    localparam int unsigned DT_W     = 6;
    localparam int unsigned PHINC_W  = 17;
    localparam int unsigned PHOP_W   = 10;

    typedef struct packed {
        logic [KC_W-1:0]    kc;
        logic [DT_W-1:0]    dt;
        logic [PHINC_W-1:0] phinc;
    } pg_stage2_t;

endpackage

// File: rtl/jt12_pg_comb.sv
// Combinational phase arithmetic: stage-I increment/keycode/detune and
// the stage-II phase-sum feeding the circular phase store.
module jt12_pg_comb
    import jt12_pg_seq_pkg::*;
#(
    parameter int unsigned PW = PG_PW
) (
    input  logic [2:0]    i_block,
    input  logic [10:0]   i_fnum,
    input  logic [4:0]    i_lfo_mod,
    input  logic [2:0]    i_pms,
    input  logic [2:0]    i_detune,
    output logic [4:0]    o_keycode,
    output logic [5:0]    o_detune,
    output logic [16:0]   o_phinc,
    input  logic [16:0]   i_phinc_II,
    input  logic [5:0]    i_detune_II,
    input  logic [3:0]    i_mul_II,
    input  logic          i_keyon_II,
    input  logic [PW-1:0] i_phase_in,
    output logic [PW-1:0] o_phase_out
);

    logic [10:0]   w_pm_prod;
    logic [10:0]   w_pm_off;
    logic [11:0]   w_fmod;
    logic [18:0]   w_phinc_wide;
    logic [5:0]    w_dt_mag;
    logic [PW-1:0] w_sum;
    logic [PW-1:0] w_scaled;

    always_comb begin
        o_keycode = {i_block, i_fnum[10],
                     i_fnum[10] ? (|i_fnum[9:7]) : (&i_fnum[9:7])};

        // LFO PM: sign in bit 4, magnitude scaled by the top fnum bits and pms
        w_pm_prod = 11'(i_fnum[10:4]) * 11'(i_lfo_mod[3:0]);
        w_pm_off  = (i_pms == 3'd0) ? '0 : (w_pm_prod >> (4'd8 - {1'b0, i_pms}));
        if (i_lfo_mod[4])
            w_fmod = ({1'b0, i_fnum} < {1'b0, w_pm_off}) ? '0
                   : ({1'b0, i_fnum} - {1'b0, w_pm_off});
        else
            w_fmod = {1'b0, i_fnum} + {1'b0, w_pm_off};

        w_phinc_wide = (19'(w_fmod) << i_block) >> 1;
        o_phinc      = (|w_phinc_wide[18:17]) ? '1 : w_phinc_wide[16:0];

        w_dt_mag = 6'(i_detune[1:0]) * (6'(o_keycode[4:2]) + 6'd1);
        o_detune = i_detune[2] ? (6'd0 - w_dt_mag) : w_dt_mag;
    end

    always_comb begin
        w_sum       = PW'(i_phinc_II) + {{(PW-6){i_detune_II[5]}}, i_detune_II};
        w_scaled    = (i_mul_II == 4'd0) ? (w_sum >> 1) : (w_sum * PW'(i_mul_II));
        o_phase_out = i_keyon_II ? '0 : (i_phase_in + w_scaled);
    end

endmodule

// File: rtl/jt12_pg_seq.sv
// Slot sequencer for the 24 FM operator slots: counter, stage II/III
// pipeline registers and the 24-deep circular phase store.
module jt12_pg_seq
    import jt12_pg_seq_pkg::*;
#(
    parameter int unsigned SLOTS = PG_SLOTS,
    parameter int unsigned PW    = PG_PW
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_en,
    input  logic [2:0]  block_I,
    input  logic [10:0] fnum_I,
    input  logic [4:0]  lfo_mod,
    input  logic [2:0]  pms_I,
    input  logic [2:0]  detune_I,
    input  logic [3:0]  mul_II,
    input  logic        keyon_II,
    output logic [4:0]  keycode_II,
    output logic [9:0]  phase_op_III,
    output logic [4:0]  slot_III,
    output logic        zero
);

    pg_stage2_t    r_st2;
    logic [4:0]    r_cnt;
    logic [4:0]    r_slot_II;
    logic [4:0]    r_slot_III;
    logic          r_zero;
    logic [PW-1:0] r_store [SLOTS];

    logic [4:0]    w_keycode;
    logic [5:0]    w_detune;
    logic [16:0]   w_phinc;
    logic [PW-1:0] w_phase_out;

    jt12_pg_comb #(
        .PW (PW)
    ) u_comb (
        .i_block     (block_I),
        .i_fnum      (fnum_I),
        .i_lfo_mod   (lfo_mod),
        .i_pms       (pms_I),
        .i_detune    (detune_I),
        .o_keycode   (w_keycode),
        .o_detune    (w_detune),
        .o_phinc     (w_phinc),
        .i_phinc_II  (r_st2.phinc),
        .i_detune_II (r_st2.dt),
        .i_mul_II    (mul_II),
        .i_keyon_II  (keyon_II),
        .i_phase_in  (r_store[SLOTS-1]),
        .o_phase_out (w_phase_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_zero     <= 1'b0;
            r_st2      <= '0;
            r_slot_II  <= '0;
            r_slot_III <= '0;
            for (int unsigned i = 0; i < SLOTS; i++)
                r_store[i] <= '0;
        end else if (clk_en) begin
            r_cnt      <= (r_cnt == 5'(SLOTS-1)) ? 5'd0 : r_cnt + 5'd1;
            r_zero     <= (r_cnt == 5'd0);
            r_st2      <= '{kc: w_keycode, dt: w_detune, phinc: w_phinc};
            r_slot_II  <= r_cnt;
            r_slot_III <= r_slot_II;
            // head holds the stage-III result, so it doubles as the phase_op register
            r_store[0] <= w_phase_out;
            for (int unsigned i = 1; i < SLOTS; i++)
                r_store[i] <= r_store[i-1];
        end
    end

    assign keycode_II   = r_st2.kc;
    assign phase_op_III = r_store[0][PW-1 -: PHOP_W];
    assign slot_III     = r_slot_III;
    assign zero         = r_zero;

endmodule
